// File: rtl/bank_pkg.sv
// Shared definitions for the cache-bank storage controller: opcodes, per-offset
// cacheline states, SC FSM state encoding and the latched request record.
package bank_pkg;

    localparam logic [2:0] OP_READ          = 3'd0;
    localparam logic [2:0] OP_WRITE         = 3'd1;
    localparam logic [2:0] OP_LINEFILL      = 3'd2;
    localparam logic [2:0] OP_LINEFILL_READ = 3'd3;

    localparam logic [1:0] CL_CLEAN = 2'b00;
    localparam logic [1:0] CL_DIRTY = 2'b01;
    localparam logic [1:0] CL_EMPTY = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DAT,
        ST_WB_REQ,
        ST_WB_WR,
        ST_LF_W0,
        ST_LF_W1,
        ST_RESP
    } sc_state_e;

    typedef struct packed {
        logic [1:0]   ch;
        logic [2:0]   op;
        logic [6:0]   addr;
        logic [7:0]   wbid;
        logic [2:0]   rob;
        logic [1:0]   st0;
        logic [1:0]   st1;
        logic [127:0] ld0;
        logic [127:0] ld1;
    } sc_req_t;

endpackage

// File: rtl/bank_sc_credit_ctr.sv
// Per-channel xbar credit counter: decrements on send, increments on return,
// saturates at CREDIT_INIT; flags when no credit is left.
module bank_sc_credit_ctr #(
    parameter int unsigned CREDIT_INIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic send_i,
    input  logic ret_i,
    output logic zero_o
);

    localparam logic [2:0] CMAX = 3'(CREDIT_INIT);

    logic [2:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= CMAX;
        end else if (send_i && !ret_i) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 3'd1;
        end else if (ret_i && !send_i && cnt_q != CMAX) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign zero_o = (cnt_q == '0);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ret_i && !send_i && cnt_q == CMAX));

endmodule

// File: rtl/bank_sc_ctrl.sv
// Cache-bank storage controller: sequences ISU requests onto the data SRAM and
// write buffer, returns read data to the xbar under credit flow control.
// Optional input skid register: define BANK_SC_SKID_EN.
module bank_sc_ctrl
    import bank_pkg::*;
#(
    parameter int unsigned CREDIT_INIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         isu_sc_valid_i,
    output logic         isu_sc_ready_o,
    input  logic [1:0]   isu_sc_channel_id_i,
    input  logic [2:0]   isu_sc_opcode_i,
    input  logic [6:0]   isu_sc_set_way_offset_i,
    input  logic [7:0]   isu_sc_wbuffer_id_i,
    input  logic [2:0]   isu_sc_xbar_rob_num_i,
    input  logic [1:0]   isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]   isu_sc_cacheline_dirty_offset1_i,
    input  logic [127:0] isu_sc_linefill_data_offset0_i,
    input  logic [127:0] isu_sc_linefill_data_offset1_i,
    output logic         sc_dat_cen_o,
    output logic         sc_dat_wen_o,
    output logic [6:0]   sc_dat_addr_o,
    output logic [127:0] sc_dat_wdata_o,
    input  logic [127:0] dat_sc_rdata_i,
    output logic         sc_wbuf_ren_o,
    output logic [7:0]   sc_wbuf_raddr_o,
    input  logic [127:0] wbuf_sc_rdata_i,
    output logic         sc_xbar_valid_o,
    output logic [1:0]   sc_xbar_ch_id_o,
    output logic [2:0]   sc_xbar_rob_num_o,
    output logic [127:0] sc_xbar_rdata_o,
    input  logic [2:0]   xbar_sc_credit_ret_i
);

    sc_state_e    state_q, state_d;
    sc_req_t      in_req, new_req, req_q;
    logic         take;
    logic         send, cred_ok;
    logic [2:0]   cred_zero;
    logic [127:0] resp_data_q;
    logic [1:0]   resp_ch_q;
    logic [2:0]   resp_rob_q;

    always_comb begin
        in_req      = '0;
        in_req.ch   = isu_sc_channel_id_i;
        in_req.op   = isu_sc_opcode_i;
        in_req.addr = isu_sc_set_way_offset_i;
        in_req.wbid = isu_sc_wbuffer_id_i;
        in_req.rob  = isu_sc_xbar_rob_num_i;
        in_req.st0  = isu_sc_cacheline_dirty_offset0_i;
        in_req.st1  = isu_sc_cacheline_dirty_offset1_i;
        in_req.ld0  = isu_sc_linefill_data_offset0_i;
        in_req.ld1  = isu_sc_linefill_data_offset1_i;
    end

`ifdef BANK_SC_SKID_EN
    logic    skid_valid_q;
    sc_req_t skid_q;

    // While busy a live request parks in the skid entry; IDLE drains it before the live input.
    assign isu_sc_ready_o = !skid_valid_q;
    assign take           = (state_q == ST_IDLE) && (skid_valid_q || isu_sc_valid_i);
    assign new_req        = skid_valid_q ? skid_q : in_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (state_q == ST_IDLE && skid_valid_q) begin
            skid_valid_q <= 1'b0;
        end else if (isu_sc_valid_i && !skid_valid_q && state_q != ST_IDLE) begin
            skid_valid_q <= 1'b1;
            skid_q       <= in_req;
        end
    end
`else
    assign isu_sc_ready_o = (state_q == ST_IDLE);
    assign take           = isu_sc_ready_o && isu_sc_valid_i;
    assign new_req        = in_req;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            resp_data_q <= '0;
            resp_ch_q   <= '0;
            resp_rob_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) req_q <= new_req;
            if (state_q == ST_RD_DAT) begin
                resp_data_q <= dat_sc_rdata_i;
                resp_ch_q   <= req_q.ch;
                resp_rob_q  <= req_q.rob;
            end else if (state_q == ST_LF_W1 && req_q.op == OP_LINEFILL_READ
                         && (req_q.addr[0] ? req_q.st1 : req_q.st0) == CL_EMPTY) begin
                resp_data_q <= req_q.addr[0] ? req_q.ld1 : req_q.ld0;
                resp_ch_q   <= req_q.ch;
                resp_rob_q  <= req_q.rob;
            end
        end
    end

    always_comb begin
        case (resp_ch_q)
            2'd0:    cred_ok = !cred_zero[0];
            2'd1:    cred_ok = !cred_zero[1];
            2'd2:    cred_ok = !cred_zero[2];
            default: cred_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        sc_dat_cen_o    = 1'b0;
        sc_dat_wen_o    = 1'b0;
        sc_dat_addr_o   = '0;
        sc_dat_wdata_o  = '0;
        sc_wbuf_ren_o   = 1'b0;
        sc_wbuf_raddr_o = '0;
        send            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    case (new_req.op)
                        OP_READ:                       state_d = ST_RD_REQ;
                        OP_WRITE:                      state_d = ST_WB_REQ;
                        OP_LINEFILL, OP_LINEFILL_READ: state_d = ST_LF_W0;
                        default:                       state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RD_REQ: begin
                sc_dat_cen_o  = 1'b1;
                sc_dat_addr_o = req_q.addr;
                state_d       = ST_RD_DAT;
            end
            ST_RD_DAT: state_d = ST_RESP;
            ST_WB_REQ: begin
                sc_wbuf_ren_o   = 1'b1;
                sc_wbuf_raddr_o = req_q.wbid;
                state_d         = ST_WB_WR;
            end
            ST_WB_WR: begin
                sc_dat_cen_o   = 1'b1;
                sc_dat_wen_o   = 1'b1;
                sc_dat_addr_o  = req_q.addr;
                sc_dat_wdata_o = wbuf_sc_rdata_i;
                state_d        = ST_IDLE;
            end
            ST_LF_W0: begin
                if (req_q.st0 == CL_EMPTY) begin
                    sc_dat_cen_o   = 1'b1;
                    sc_dat_wen_o   = 1'b1;
                    sc_dat_addr_o  = {req_q.addr[6:1], 1'b0};
                    sc_dat_wdata_o = req_q.ld0;
                end
                state_d = ST_LF_W1;
            end
            ST_LF_W1: begin
                if (req_q.st1 == CL_EMPTY) begin
                    sc_dat_cen_o   = 1'b1;
                    sc_dat_wen_o   = 1'b1;
                    sc_dat_addr_o  = {req_q.addr[6:1], 1'b1};
                    sc_dat_wdata_o = req_q.ld1;
                end
                if (req_q.op != OP_LINEFILL_READ)
                    state_d = ST_IDLE;
                else if ((req_q.addr[0] ? req_q.st1 : req_q.st0) == CL_EMPTY)
                    state_d = ST_RESP;
                else
                    state_d = ST_RD_REQ;
            end
            ST_RESP: begin
                if (cred_ok) begin
                    send    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar n = 0; n < 3; n++) begin : g_cred
        bank_sc_credit_ctr #(.CREDIT_INIT(CREDIT_INIT)) u_ctr (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .send_i (send && (resp_ch_q == 2'(n))),
            .ret_i  (xbar_sc_credit_ret_i[n]),
            .zero_o (cred_zero[n])
        );
    end

    assign sc_xbar_valid_o   = send;
    assign sc_xbar_ch_id_o   = resp_ch_q;
    assign sc_xbar_rob_num_o = resp_rob_q;
    assign sc_xbar_rdata_o   = resp_data_q;

    a_legal_channel: assert property (@(posedge clk_i) disable iff (rst_i)
        take |-> (new_req.ch != 2'd3));

endmodule

// File: tb/tb_bank_sc_ctrl.sv
// Scoreboard bench for bank_sc_ctrl: directed requests push expected SRAM,
// write-buffer and xbar events; monitors pop and compare as the DUT emits them.
module tb_bank_sc_ctrl;
    import bank_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         isu_sc_valid_i = 1'b0;
    logic         isu_sc_ready_o;
    logic [1:0]   isu_sc_channel_id_i = '0;
    logic [2:0]   isu_sc_opcode_i = '0;
    logic [6:0]   isu_sc_set_way_offset_i = '0;
    logic [7:0]   isu_sc_wbuffer_id_i = '0;
    logic [2:0]   isu_sc_xbar_rob_num_i = '0;
    logic [1:0]   isu_sc_cacheline_dirty_offset0_i = '0;
    logic [1:0]   isu_sc_cacheline_dirty_offset1_i = '0;
    logic [127:0] isu_sc_linefill_data_offset0_i = '0;
    logic [127:0] isu_sc_linefill_data_offset1_i = '0;
    logic         sc_dat_cen_o, sc_dat_wen_o;
    logic [6:0]   sc_dat_addr_o;
    logic [127:0] sc_dat_wdata_o;
    logic [127:0] dat_sc_rdata_i = '0;
    logic         sc_wbuf_ren_o;
    logic [7:0]   sc_wbuf_raddr_o;
    logic [127:0] wbuf_sc_rdata_i = '0;
    logic         sc_xbar_valid_o;
    logic [1:0]   sc_xbar_ch_id_o;
    logic [2:0]   sc_xbar_rob_num_o;
    logic [127:0] sc_xbar_rdata_o;
    logic [2:0]   xbar_sc_credit_ret_i = '0;

    bank_sc_ctrl #(.CREDIT_INIT(4)) dut (
        .clk_i                            (clk_i),
        .rst_i                            (rst_i),
        .isu_sc_valid_i                   (isu_sc_valid_i),
        .isu_sc_ready_o                   (isu_sc_ready_o),
        .isu_sc_channel_id_i              (isu_sc_channel_id_i),
        .isu_sc_opcode_i                  (isu_sc_opcode_i),
        .isu_sc_set_way_offset_i          (isu_sc_set_way_offset_i),
        .isu_sc_wbuffer_id_i              (isu_sc_wbuffer_id_i),
        .isu_sc_xbar_rob_num_i            (isu_sc_xbar_rob_num_i),
        .isu_sc_cacheline_dirty_offset0_i (isu_sc_cacheline_dirty_offset0_i),
        .isu_sc_cacheline_dirty_offset1_i (isu_sc_cacheline_dirty_offset1_i),
        .isu_sc_linefill_data_offset0_i   (isu_sc_linefill_data_offset0_i),
        .isu_sc_linefill_data_offset1_i   (isu_sc_linefill_data_offset1_i),
        .sc_dat_cen_o                     (sc_dat_cen_o),
        .sc_dat_wen_o                     (sc_dat_wen_o),
        .sc_dat_addr_o                    (sc_dat_addr_o),
        .sc_dat_wdata_o                   (sc_dat_wdata_o),
        .dat_sc_rdata_i                   (dat_sc_rdata_i),
        .sc_wbuf_ren_o                    (sc_wbuf_ren_o),
        .sc_wbuf_raddr_o                  (sc_wbuf_raddr_o),
        .wbuf_sc_rdata_i                  (wbuf_sc_rdata_i),
        .sc_xbar_valid_o                  (sc_xbar_valid_o),
        .sc_xbar_ch_id_o                  (sc_xbar_ch_id_o),
        .sc_xbar_rob_num_o                (sc_xbar_rob_num_o),
        .sc_xbar_rdata_o                  (sc_xbar_rdata_o),
        .xbar_sc_credit_ret_i             (xbar_sc_credit_ret_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event or timeout, required none", name);
    endtask

    typedef struct { logic wen; logic [6:0] addr; logic [127:0] wdata; int cyc; } mem_t;
    typedef struct { logic [7:0] addr; int cyc; } wb_t;
    typedef struct { logic [1:0] ch; logic [2:0] rob; logic [127:0] data; int cyc; } rsp_t;

    mem_t mem_q[$];
    wb_t  wb_q[$];
    rsp_t rsp_q[$];
    mem_t mon_m;
    wb_t  mon_w;
    rsp_t mon_r;

    // SRAM and write-buffer stand-ins with fixed per-address read data, 1-cycle latency
    always @(posedge clk_i) begin
        if (sc_dat_cen_o && !sc_dat_wen_o)
            dat_sc_rdata_i <= (sc_dat_addr_o == 7'h15) ? 128'hA5 :
                              (sc_dat_addr_o == 7'h2B) ? 128'h1234 : {121'h0, sc_dat_addr_o};
        if (sc_wbuf_ren_o)
            wbuf_sc_rdata_i <= (sc_wbuf_raddr_o == 8'h20) ? 128'h77 : {120'h0, sc_wbuf_raddr_o};
    end

    always @(posedge clk_i) begin
        #1;
        if (sc_dat_cen_o) begin
            if (mem_q.size() == 0) fail_now("sram_unexpected");
            else begin
                mon_m = mem_q.pop_front();
                chk("sram_wen", sc_dat_wen_o, mon_m.wen);
                chk("sram_addr", sc_dat_addr_o, mon_m.addr);
                chk("sram_wdata", sc_dat_wdata_o, mon_m.wdata);
                chk("sram_cycle", cyc, mon_m.cyc);
            end
        end
        if (sc_wbuf_ren_o) begin
            if (wb_q.size() == 0) fail_now("wbuf_unexpected");
            else begin
                mon_w = wb_q.pop_front();
                chk("wbuf_raddr", sc_wbuf_raddr_o, mon_w.addr);
                chk("wbuf_cycle", cyc, mon_w.cyc);
            end
        end
        if (sc_xbar_valid_o) begin
            if (rsp_q.size() == 0) fail_now("xbar_unexpected");
            else begin
                mon_r = rsp_q.pop_front();
                chk("xbar_ch", sc_xbar_ch_id_o, mon_r.ch);
                chk("xbar_rob", sc_xbar_rob_num_o, mon_r.rob);
                chk("xbar_data", sc_xbar_rdata_o, mon_r.data);
                chk("xbar_cycle", cyc, mon_r.cyc);
            end
        end
    end

    // Leaves valid high with the request fields driven; acc is the accepting cycle
    task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [6:0] addr,
                         input logic [7:0] wbid, input logic [2:0] rob, input logic [1:0] s0,
                         input logic [1:0] s1, input logic [127:0] d0, input logic [127:0] d1,
                         output int acc);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!isu_sc_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        acc = cyc;
        if (!isu_sc_ready_o) begin
            fail_now("ready_timeout");
            isu_sc_valid_i = 1'b0;
            return;
        end
        isu_sc_opcode_i                  = op;
        isu_sc_channel_id_i              = ch;
        isu_sc_set_way_offset_i          = addr;
        isu_sc_wbuffer_id_i              = wbid;
        isu_sc_xbar_rob_num_i            = rob;
        isu_sc_cacheline_dirty_offset0_i = s0;
        isu_sc_cacheline_dirty_offset1_i = s1;
        isu_sc_linefill_data_offset0_i   = d0;
        isu_sc_linefill_data_offset1_i   = d1;
        isu_sc_valid_i                   = 1'b1;
    endtask

    task automatic release_req();
        @(negedge clk_i);
        isu_sc_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mem_q.size() + wb_q.size() + rsp_q.size()) != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if ((mem_q.size() + wb_q.size() + rsp_q.size()) != 0) begin
            fail_now("drain_timeout");
            mem_q.delete();
            wb_q.delete();
            rsp_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    task automatic ret_credit(input int ch);
        xbar_sc_credit_ret_i[ch] = 1'b1;
        @(negedge clk_i);
        xbar_sc_credit_ret_i = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, isu_sc_ready_o, 1'b1);
        chk({tag, "_cen"}, sc_dat_cen_o, 1'b0);
        chk({tag, "_wen"}, sc_dat_wen_o, 1'b0);
        chk({tag, "_ren"}, sc_wbuf_ren_o, 1'b0);
        chk({tag, "_valid"}, sc_xbar_valid_o, 1'b0);
        chk({tag, "_ch"}, sc_xbar_ch_id_o, 2'd0);
        chk({tag, "_rob"}, sc_xbar_rob_num_o, 3'd0);
        chk({tag, "_rdata"}, sc_xbar_rdata_o, 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, r;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;

        // READ 0x15 on ch1
        issue(OP_READ, 2'd1, 7'h15, 8'h0, 3'd5, CL_CLEAN, CL_CLEAN, '0, '0, a);
        mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
        rsp_q.push_back('{2'd1, 3'd5, 128'hA5, a + 3});
        release_req();
        drain();
        ret_credit(1);

        // WRITE from write-buffer entry 0x20, no response
        issue(OP_WRITE, 2'd0, 7'h33, 8'h20, 3'd2, CL_CLEAN, CL_CLEAN, '0, '0, a);
        wb_q.push_back('{8'h20, a + 1});
        mem_q.push_back('{1'b1, 7'h33, 128'h77, a + 2});
        release_req();
        drain();

        // LINEFILL_READ offset1, offset1 dirty: fill offset0 then read offset1
        issue(OP_LINEFILL_READ, 2'd2, 7'h2B, 8'h0, 3'd7, CL_EMPTY, CL_DIRTY, 128'h64, 128'hC8, a);
        mem_q.push_back('{1'b1, 7'h2A, 128'h64, a + 1});
        mem_q.push_back('{1'b0, 7'h2B, 128'h0, a + 3});
        rsp_q.push_back('{2'd2, 3'd7, 128'h1234, a + 5});
        release_req();
        drain();

        // LINEFILL_READ offset1 from empty: response from linefill data
        issue(OP_LINEFILL_READ, 2'd2, 7'h2B, 8'h0, 3'd3, CL_DIRTY, CL_EMPTY, 128'h64, 128'hC8, a);
        mem_q.push_back('{1'b1, 7'h2B, 128'hC8, a + 2});
        rsp_q.push_back('{2'd2, 3'd3, 128'hC8, a + 3});
        release_req();
        drain();

        // Drain ch0 credits; the fifth read waits for a returned credit
        for (int i = 0; i < 4; i++) begin
            issue(OP_READ, 2'd0, 7'h15, 8'h0, 3'(i), CL_CLEAN, CL_CLEAN, '0, '0, a);
            mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
            rsp_q.push_back('{2'd0, 3'(i), 128'hA5, a + 3});
            release_req();
            drain();
        end
        issue(OP_READ, 2'd0, 7'h15, 8'h0, 3'd4, CL_CLEAN, CL_CLEAN, '0, '0, a);
        mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
        release_req();
        wait_cycle(a + 6);
        r = cyc;
        rsp_q.push_back('{2'd0, 3'd4, 128'hA5, r + 1});
        ret_credit(0);
        drain();

`ifdef BANK_SC_SKID_EN
        // Back-to-back, no stall: second request sits in the skid entry
        issue(OP_READ, 2'd1, 7'h15, 8'h0, 3'd1, CL_CLEAN, CL_CLEAN, '0, '0, a);
        mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
        rsp_q.push_back('{2'd1, 3'd1, 128'hA5, a + 3});
        issue(OP_READ, 2'd1, 7'h2B, 8'h0, 3'd2, CL_CLEAN, CL_CLEAN, '0, '0, b);
        chk("skid_accept_cycle", b, a + 1);
        mem_q.push_back('{1'b0, 7'h2B, 128'h0, a + 5});
        rsp_q.push_back('{2'd1, 3'd2, 128'h1234, a + 7});
        release_req();
        drain();

        // Back-to-back with the first parked in RESP (ch0 has no credit)
        issue(OP_READ, 2'd0, 7'h15, 8'h0, 3'd3, CL_CLEAN, CL_CLEAN, '0, '0, a);
        mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
        issue(OP_READ, 2'd1, 7'h2B, 8'h0, 3'd4, CL_CLEAN, CL_CLEAN, '0, '0, b);
        chk("skid_stall_accept_cycle", b, a + 1);
        release_req();
        wait_cycle(a + 6);
        r = cyc;
        rsp_q.push_back('{2'd0, 3'd3, 128'hA5, r + 1});
        mem_q.push_back('{1'b0, 7'h2B, 128'h0, r + 3});
        rsp_q.push_back('{2'd1, 3'd4, 128'h1234, r + 5});
        ret_credit(0);
        drain();
`endif

        // Reset while in LF_W1
        issue(OP_LINEFILL, 2'd2, 7'h40, 8'h0, 3'd1, CL_EMPTY, CL_EMPTY, 128'h11, 128'h22, a);
        mem_q.push_back('{1'b1, 7'h40, 128'h11, a + 1});
        mem_q.push_back('{1'b1, 7'h41, 128'h22, a + 2});
        release_req();
        wait_cycle(a + 2);
        rst_i = 1'b1;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // ch0 credits restored: no stall after reset
        issue(OP_READ, 2'd0, 7'h15, 8'h0, 3'd6, CL_CLEAN, CL_CLEAN, '0, '0, a);
        mem_q.push_back('{1'b0, 7'h15, 128'h0, a + 1});
        rsp_q.push_back('{2'd0, 3'd6, 128'hA5, a + 3});
        release_req();
        drain();

        chk("queues_empty", mem_q.size() + wb_q.size() + rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
